// File: rtl/remote_comm.sv
// remote_comm: host-side command sender with an embedded 8N1 UART.
// A 16-bit command is sent as two UART bytes (high byte first). The block
// then waits for one response byte from the far end, or times out.
//
// Ports:
//   clk, rst_n       system clock, asynchronous active-low reset
//   snd_cmd, cmd     one-cycle send request and the 16-bit command word
//   RX, TX           serial in from / serial out to the far end
//   busy             high while a command/response exchange is in flight
//   cmd_snt          both command bytes have left the transmitter
//   resp, resp_rdy   last response byte (8'h00 on timeout) and its valid flag
//   resp_tmo         the last exchange ended in a response timeout
//
// Parameters:
//   RESP_TMO   clk cycles to wait for the response byte (>= 1)
//   BAUD_DIV   clk cycles per UART bit (>= 4)
module remote_comm #(
    parameter int unsigned RESP_TMO = 1_000_000,
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        snd_cmd,
    input  logic [15:0] cmd,
    input  logic        RX,
    output logic        TX,
    output logic        busy,
    output logic        cmd_snt,
    output logic [7:0]  resp,
    output logic        resp_rdy,
    output logic        resp_tmo
);

    localparam int unsigned TMO_W  = (RESP_TMO > 1) ? $clog2(RESP_TMO) : 1;
    localparam int unsigned BAUD_W = $clog2(BAUD_DIV);
    localparam int unsigned BIT_W  = 4;

    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(RESP_TMO - 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(BAUD_DIV / 2 - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(9);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TX_HIGH   = 2'd1,
        TX_LOW    = 2'd2,
        WAIT_RESP = 2'd3
    } state_t;

    // Sender state
    state_t             state_q, state_d;
    logic [15:0]        cmd_hold_q, cmd_hold_d;
    logic               trmt_q, trmt_d;
    logic               busy_q, busy_d;
    logic               cmd_snt_q, cmd_snt_d;
    logic [7:0]         resp_q, resp_d;
    logic               resp_rdy_q, resp_rdy_d;
    logic               resp_tmo_q, resp_tmo_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               clr_rx_rdy_q, clr_rx_rdy_d;

    // UART transmitter
    logic [7:0]         tx_data_c;
    logic [9:0]         tx_shft_q, tx_shft_d;
    logic [BAUD_W-1:0]  tx_baud_q, tx_baud_d;
    logic [BIT_W-1:0]   tx_bit_q, tx_bit_d;
    logic               tx_busy_q, tx_busy_d;
    logic               tx_done_q, tx_done_d;

    // UART receiver
    logic               rx_meta_q, rx_s_q;
    logic [9:0]         rx_shft_q, rx_shft_d;
    logic [BAUD_W-1:0]  rx_baud_q, rx_baud_d;
    logic [BIT_W-1:0]   rx_bit_q, rx_bit_d;
    logic               rx_busy_q, rx_busy_d;
    logic               rx_rdy_q, rx_rdy_d;
    logic [7:0]         rx_data_q, rx_data_d;

    // Byte presented to the transmitter follows the sender state
    always_comb begin
        tx_data_c = (state_q == TX_LOW) ? cmd_hold_q[7:0] : cmd_hold_q[15:8];
    end

    // Transmitter: start bit, 8 data bits LSB first, stop bit; shifts in ones
    always_comb begin
        tx_shft_d = tx_shft_q;
        tx_baud_d = tx_baud_q;
        tx_bit_d  = tx_bit_q;
        tx_busy_d = tx_busy_q;
        tx_done_d = tx_done_q;
        if (trmt_q) begin
            tx_shft_d = {1'b1, tx_data_c, 1'b0};
            tx_baud_d = '0;
            tx_bit_d  = '0;
            tx_busy_d = 1'b1;
            tx_done_d = 1'b0;
        end else if (tx_busy_q) begin
            if (tx_baud_q == BAUD_LAST) begin
                tx_baud_d = '0;
                tx_shft_d = {1'b1, tx_shft_q[9:1]};
                if (tx_bit_q == BIT_LAST) begin
                    tx_busy_d = 1'b0;
                    tx_done_d = 1'b1;
                end else begin
                    tx_bit_d = tx_bit_q + BIT_W'(1);
                end
            end else begin
                tx_baud_d = tx_baud_q + BAUD_W'(1);
            end
        end
    end

    // Receiver: mid-bit sampling of 10 bits; a high start sample is a glitch
    always_comb begin
        rx_shft_d = rx_shft_q;
        rx_baud_d = rx_baud_q;
        rx_bit_d  = rx_bit_q;
        rx_busy_d = rx_busy_q;
        rx_data_d = rx_data_q;
        rx_rdy_d  = rx_rdy_q & ~clr_rx_rdy_q;
        if (!rx_busy_q) begin
            if (!rx_s_q) begin
                rx_busy_d = 1'b1;
                rx_baud_d = BAUD_HALF;
                rx_bit_d  = '0;
                rx_rdy_d  = 1'b0;
            end
        end else if (rx_baud_q == '0) begin
            rx_shft_d = {rx_s_q, rx_shft_q[9:1]};
            rx_baud_d = BAUD_LAST;
            if (rx_bit_q == BIT_LAST) begin
                rx_busy_d = 1'b0;
                if (!rx_shft_d[0] && rx_shft_d[9]) begin
                    rx_rdy_d  = 1'b1;
                    rx_data_d = rx_shft_d[8:1];
                end
            end else if ((rx_bit_q == '0) && rx_s_q) begin
                rx_busy_d = 1'b0;
            end else begin
                rx_bit_d = rx_bit_q + BIT_W'(1);
            end
        end else begin
            rx_baud_d = rx_baud_q - BAUD_W'(1);
        end
    end

    // Sender state machine: next state and registered outputs
    always_comb begin
        state_d    = state_q;
        cmd_hold_d = cmd_hold_q;
        trmt_d     = 1'b0;
        busy_d     = busy_q;
        cmd_snt_d  = cmd_snt_q;
        resp_d     = resp_q;
        resp_rdy_d = resp_rdy_q;
        resp_tmo_d = resp_tmo_q;
        tmo_cnt_d  = tmo_cnt_q;
        // Any received byte is acknowledged once; only WAIT_RESP keeps its data
        clr_rx_rdy_d = rx_rdy_q & ~clr_rx_rdy_q;
        case (state_q)
            IDLE: begin
                if (snd_cmd) begin
                    cmd_hold_d = cmd;
                    cmd_snt_d  = 1'b0;
                    resp_rdy_d = 1'b0;
                    resp_tmo_d = 1'b0;
                    trmt_d     = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = TX_HIGH;
                end
            end
            // tx_done is stale while trmt is still high, so skip that cycle
            TX_HIGH: begin
                if (tx_done_q && !trmt_q) begin
                    trmt_d  = 1'b1;
                    state_d = TX_LOW;
                end
            end
            TX_LOW: begin
                if (tx_done_q && !trmt_q) begin
                    cmd_snt_d = 1'b1;
                    tmo_cnt_d = '0;
                    state_d   = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                if (rx_rdy_q && !clr_rx_rdy_q) begin
                    resp_d     = rx_data_q;
                    resp_rdy_d = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    resp_d     = 8'h00;
                    resp_rdy_d = 1'b1;
                    resp_tmo_d = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cmd_hold_q   <= '0;
            trmt_q       <= 1'b0;
            busy_q       <= 1'b0;
            cmd_snt_q    <= 1'b0;
            resp_q       <= 8'h00;
            resp_rdy_q   <= 1'b0;
            resp_tmo_q   <= 1'b0;
            tmo_cnt_q    <= '0;
            clr_rx_rdy_q <= 1'b0;
            tx_shft_q    <= '1;
            tx_baud_q    <= '0;
            tx_bit_q     <= '0;
            tx_busy_q    <= 1'b0;
            tx_done_q    <= 1'b0;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_shft_q    <= '1;
            rx_baud_q    <= '0;
            rx_bit_q     <= '0;
            rx_busy_q    <= 1'b0;
            rx_rdy_q     <= 1'b0;
            rx_data_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            cmd_hold_q   <= cmd_hold_d;
            trmt_q       <= trmt_d;
            busy_q       <= busy_d;
            cmd_snt_q    <= cmd_snt_d;
            resp_q       <= resp_d;
            resp_rdy_q   <= resp_rdy_d;
            resp_tmo_q   <= resp_tmo_d;
            tmo_cnt_q    <= tmo_cnt_d;
            clr_rx_rdy_q <= clr_rx_rdy_d;
            tx_shft_q    <= tx_shft_d;
            tx_baud_q    <= tx_baud_d;
            tx_bit_q     <= tx_bit_d;
            tx_busy_q    <= tx_busy_d;
            tx_done_q    <= tx_done_d;
            rx_meta_q    <= RX;
            rx_s_q       <= rx_meta_q;
            rx_shft_q    <= rx_shft_d;
            rx_baud_q    <= rx_baud_d;
            rx_bit_q     <= rx_bit_d;
            rx_busy_q    <= rx_busy_d;
            rx_rdy_q     <= rx_rdy_d;
            rx_data_q    <= rx_data_d;
        end
    end

    assign TX       = tx_shft_q[0];
    assign busy     = busy_q;
    assign cmd_snt  = cmd_snt_q;
    assign resp     = resp_q;
    assign resp_rdy = resp_rdy_q;
    assign resp_tmo = resp_tmo_q;

endmodule
